// File: rtl/mem_load_align.sv
// Load-alignment unit: turns a byte/half/word/dword load into one or two aligned
// memory reads, then extracts, extends and returns the result over valid/ready.
module mem_load_align #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int ALLOW_UNALIGNED = 0
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [1:0]        iSize,
    input  logic              iSigned,
    output logic              oMemRd,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic              iMemValid,
    input  logic [DATA_W-1:0] iMemRdata,
    output logic              roRespValid,
    input  logic              iRespReady,
    output logic [DATA_W-1:0] roRespData,
    output logic              roMisalign
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int NB_W  = OFF_W + 2;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t              state, state_nxt;
    logic [OFF_W-1:0]    off_q;
    logic [1:0]          size_q;
    logic                sgn_q;
    logic                cross_q;
    logic [DATA_W-1:0]   beat0_q;

    logic [NB_W-1:0]     req_off, req_nb;
    logic                req_misal, req_cross, req_illegal, req_reject;

    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   shifted, ext;
    logic                fill;
    int unsigned         keep;

    always_comb begin
        req_off     = NB_W'(iAddr[OFF_W-1:0]);
        req_nb      = NB_W'(1) << iSize;
        req_misal   = |(req_off & (req_nb - NB_W'(1)));
        req_cross   = (req_off + req_nb) > NB_W'(BYTES);
        req_illegal = (iSize == 2'b11) && (DATA_W != 64);
        req_reject  = req_illegal || (req_misal && (ALLOW_UNALIGNED == 0));
    end

    // The final beat comes straight from iMemRdata so the result registers on RESP entry.
    always_comb begin
        pair    = (state == WAIT1) ? {iMemRdata, beat0_q} : {{DATA_W{1'b0}}, iMemRdata};
        shifted = DATA_W'(pair >> {off_q, 3'b000});
        keep    = 32'd8 << size_q;
        case (size_q)
            2'd0:    fill = shifted[7];
            2'd1:    fill = shifted[15];
            2'd2:    fill = shifted[31];
            default: fill = shifted[DATA_W-1];
        endcase
        fill = fill & sgn_q;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            ext[i] = (i < keep) ? shifted[i] : fill;
        end
    end

    always_comb begin
        state_nxt = state;
        oReqReady = 1'b0;
        oMemRd    = 1'b0;
        case (state)
            IDLE: begin
                oReqReady = 1'b1;
                if (iReqValid) state_nxt = req_reject ? RESP : REQ0;
            end
            REQ0: begin
                oMemRd    = 1'b1;
                state_nxt = WAIT0;
            end
            WAIT0: if (iMemValid) state_nxt = cross_q ? REQ1 : RESP;
            REQ1: begin
                oMemRd    = 1'b1;
                state_nxt = WAIT1;
            end
            WAIT1: if (iMemValid) state_nxt = RESP;
            RESP:  if (iRespReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            cross_q     <= 1'b0;
            beat0_q     <= '0;
            oMemAddr    <= '0;
            roRespValid <= 1'b0;
            roRespData  <= '0;
            roMisalign  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (iReqValid) begin
                    off_q    <= iAddr[OFF_W-1:0];
                    size_q   <= iSize;
                    sgn_q    <= iSigned;
                    cross_q  <= req_cross;
                    oMemAddr <= {iAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (req_reject) begin
                        roRespValid <= 1'b1;
                        roRespData  <= '0;
                        roMisalign  <= 1'b1;
                    end
                end
                WAIT0: if (iMemValid) begin
                    beat0_q <= iMemRdata;
                    if (cross_q) begin
                        oMemAddr <= oMemAddr + ADDR_W'(BYTES);
                    end else begin
                        roRespValid <= 1'b1;
                        roRespData  <= ext;
                        roMisalign  <= 1'b0;
                    end
                end
                WAIT1: if (iMemValid) begin
                    roRespValid <= 1'b1;
                    roRespData  <= ext;
                    roMisalign  <= 1'b0;
                end
                RESP: if (iRespReady) begin
                    roRespValid <= 1'b0;
                    roMisalign  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
